mem_port_arbiter: RTL and testbench

- Shares one single-ported unified memory between instruction fetch (read-only) and the MEM-stage data port (load/store).
- Sequences each access as request, then wait-for-ack, then a one-cycle ready pulse.
- Generates byte strobes and lane-shifted write data for stores; extracts and sign- or zero-extends load data.
- Sits between the pipeline IF/MEM stages and the memory model or bus. The pipeline stalls on the deasserted ready.

---
 rtl/mem_port_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 474 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and the MEM-stage data port.
// Optional bus timeout with a sticky err flag: define MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_rdata,
  input  logic [2:0]  d_read,
  input  logic [1:0]  d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        owner,
  output logic        err
);

  localparam int unsigned SCW = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned TOW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] LD_LB  = 3'b001;
  localparam logic [2:0] LD_LH  = 3'b010;
  localparam logic [2:0] LD_LW  = 3'b011;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;

  state_e         state_q;
  logic [SCW-1:0] starve_q, starve_d;
  logic           owner_q, mem_req_q, mem_we_q;
  logic [31:0]    mem_addr_q, mem_wdata_q;
  logic [3:0]     mem_wstrb_q;
  logic           if_ready_q, d_ready_q;
  logic [31:0]    if_rdata_q, d_rdata_q;
  logic [2:0]     ld_type_q;
  logic [1:0]     ld_off_q;

  logic           d_active, gnt_data, gnt_fetch;
  logic [3:0]     st_strb;
  logic [31:0]    st_wdata;
  logic [7:0]     ld_byte;
  logic [15:0]    ld_half;
  logic [31:0]    ld_data;

  // Grant decision (only meaningful in IDLE) and starvation counter update
  always_comb begin
    d_active  = (d_read != 3'b000) || (d_write != 2'b00);
    gnt_data  = 1'b0;
    gnt_fetch = 1'b0;
    starve_d  = starve_q;
    if (state_q == IDLE) begin
      if (d_active && ((starve_q < SCW'(STARVE_LIMIT)) || !if_req)) begin
        gnt_data = 1'b1;
      end else if (if_req) begin
        gnt_fetch = 1'b1;
      end
    end
    if (!if_req || gnt_fetch) begin
      starve_d = '0;
    end else if (gnt_data && (starve_q < SCW'(STARVE_LIMIT))) begin
      starve_d = starve_q + SCW'(1);
    end
  end

  // Store lane placement
  always_comb begin
    st_strb  = 4'b0000;
    st_wdata = d_wdata;
    case (d_write)
      2'b01: begin
        st_strb  = 4'b0001 << d_addr[1:0];
        st_wdata = {4{d_wdata[7:0]}};
      end
      2'b10: begin
        st_strb  = d_addr[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{d_wdata[15:0]}};
      end
      2'b11:   st_strb = 4'b1111;
      default: st_strb = 4'b0000;
    endcase
  end

  // Load lane extraction and extension
  always_comb begin
    ld_byte = mem_rdata[{ld_off_q, 3'b000} +: 8];
    ld_half = mem_rdata[{ld_off_q[1], 4'b0000} +: 16];
    ld_data = mem_rdata;
    case (ld_type_q)
      LD_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      LD_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
      LD_LW:   ld_data = mem_rdata;
      LD_LBU:  ld_data = {24'h000000, ld_byte};
      LD_LHU:  ld_data = {16'h0000, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

`ifdef MEM_ARB_TIMEOUT_EN
  logic [TOW-1:0] tmo_q;
  logic           err_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      owner_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      if_ready_q  <= 1'b0;
      d_ready_q   <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      ld_type_q   <= '0;
      ld_off_q    <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      tmo_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      starve_q   <= starve_d;
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (gnt_data || gnt_fetch) begin
            state_q     <= BUS;
            mem_req_q   <= 1'b1;
            owner_q     <= gnt_data;
            mem_addr_q  <= gnt_data ? {d_addr[31:2], 2'b00} : {if_addr[31:2], 2'b00};
            mem_we_q    <= gnt_data && (d_write != 2'b00);
            mem_wstrb_q <= gnt_data ? st_strb : 4'b0000;
            mem_wdata_q <= gnt_data ? st_wdata : 32'h0000_0000;
            // A store alongside a load suppresses the load
            ld_type_q   <= (gnt_data && (d_write == 2'b00)) ? d_read : 3'b000;
            ld_off_q    <= d_addr[1:0];
`ifdef MEM_ARB_TIMEOUT_EN
            tmo_q       <= '0;
`endif
          end
        end
        BUS: begin
          if (mem_ack) begin
            state_q   <= RESP;
            mem_req_q <= 1'b0;
            if (owner_q) begin
              d_ready_q <= 1'b1;
              if (ld_type_q != 3'b000) begin
                d_rdata_q <= ld_data;
              end
            end else begin
              if_ready_q <= 1'b1;
              if_rdata_q <= mem_rdata;
            end
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else if (tmo_q == TOW'(TIMEOUT - 1)) begin
            state_q   <= RESP;
            mem_req_q <= 1'b0;
            err_q     <= 1'b1;
            if (owner_q) begin
              d_ready_q <= 1'b1;
              d_rdata_q <= '0;
            end else begin
              if_ready_q <= 1'b1;
              if_rdata_q <= '0;
            end
          end else begin
            tmo_q <= tmo_q + TOW'(1);
          end
`endif
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign if_ready  = if_ready_q;
  assign if_rdata  = if_rdata_q;
  assign d_ready   = d_ready_q;
  assign d_rdata   = d_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign owner     = owner_q;

`ifdef MEM_ARB_TIMEOUT_EN
  assign err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TOW'(TIMEOUT);
  assign err = 1'b0;
`endif

  // Fetch addresses are word-aligned; the low bits carry no information
  logic unused_if_lsb;
  assign unused_if_lsb = ^if_addr[1:0];

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed cases plus randomized fetch/data traffic.
module tb_mem_port_arbiter;

  localparam int unsigned SLIM  = 4;
  localparam int unsigned TMO   = 8;
  localparam int          BOUND = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic [2:0]  d_read = '0;
  logic [1:0]  d_write = '0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        owner;
  logic        err;

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_LIMIT(SLIM), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .owner(owner), .err(err)
  );

  typedef struct {
    bit          owner;
    logic [31:0] addr;
    bit          we;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    bit          owner;
    bit          chk;
    logic [31:0] data;
  } rsp_t;

  req_t req_q[$];
  rsp_t rsp_q[$];
  bit   owner_log[$];

  int errors = 0;
  int checks = 0;

  bit          sb_en = 1'b0;
  bit          hold_ack = 1'b0;
  bit          min_lat = 1'b0;
  bit          force_en = 1'b0;
  logic [31:0] force_val = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_note(input string name, input string note);
    checks++;
    errors++;
    $display("FAIL %s: %s at %0t", name, note, $time);
  endtask

  // Reference load result from the word, the load type and the byte address
  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] t,
                                           input int unsigned a);
    int unsigned b;
    int unsigned h;
    b = (int'(w) >> (8 * (a % 4))) & 32'hFF;
    h = (int'(w) >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    case (t)
      3'd1:    return (b >= 128) ? 32'(b - 256) : 32'(b);
      3'd2:    return (h >= 32768) ? 32'(h - 65536) : 32'(h);
      3'd4:    return 32'(b);
      3'd5:    return 32'(h);
      default: return w;
    endcase
  endfunction

  // Memory responder: acks after a random wait, or never while hold_ack is set
  int ack_wait = 0;
  always @(negedge clk) begin
    if (mem_ack) begin
      mem_ack = 1'b0;
    end else if (mem_req && !hold_ack) begin
      if (ack_wait == 0 || min_lat) begin
        mem_ack   = 1'b1;
        mem_rdata = force_en ? force_val : $urandom;
        ack_wait  = $urandom_range(0, 2);
      end else begin
        ack_wait--;
      end
    end
  end

  // Reference model: who wins each free slot, and what each access must look like
  int unsigned m_starve = 0;
  bit          m_busy = 1'b0;
  bit          m_resp = 1'b0;
  bit          m_owner = 1'b0;
  bit          m_gd, m_gf, m_dact;
  logic [2:0]  m_ld = '0;
  int unsigned m_off = 0;
  int unsigned m_a;
  req_t        m_e;
  rsp_t        m_r;

  always @(posedge clk) begin
    if (rst || !sb_en) begin
      m_starve = 0;
      m_busy   = 1'b0;
      m_resp   = 1'b0;
    end else begin
      m_gd = 1'b0;
      m_gf = 1'b0;
      if (m_busy) begin
        if (mem_ack) begin
          m_busy  = 1'b0;
          m_resp  = 1'b1;
          m_r.owner = m_owner;
          if (!m_owner) begin
            m_r.chk  = 1'b1;
            m_r.data = mem_rdata;
          end else begin
            m_r.chk  = (m_ld != 3'd0);
            m_r.data = ref_load(mem_rdata, m_ld, m_off);
          end
          rsp_q.push_back(m_r);
        end
      end else if (m_resp) begin
        m_resp = 1'b0;
      end else begin
        m_dact = (d_read != 3'd0) || (d_write != 2'd0);
        if (m_dact && (m_starve < SLIM || !if_req)) m_gd = 1'b1;
        else if (if_req) m_gf = 1'b1;
        if (m_gd) begin
          m_a       = d_addr;
          m_e.owner = 1'b1;
          m_e.addr  = 32'(m_a - (m_a % 4));
          m_e.we    = (d_write != 2'd0);
          case (d_write)
            2'd1: begin
              m_e.strb  = 4'(1 << (m_a % 4));
              m_e.wdata = 32'((int'(d_wdata) & 255) * 32'h0101_0101);
            end
            2'd2: begin
              m_e.strb  = ((m_a % 4) >= 2) ? 4'hC : 4'h3;
              m_e.wdata = 32'((int'(d_wdata) & 32'hFFFF) * 32'h0001_0001);
            end
            2'd3: begin
              m_e.strb  = 4'hF;
              m_e.wdata = d_wdata;
            end
            default: begin
              m_e.strb  = 4'h0;
              m_e.wdata = '0;
            end
          endcase
          m_ld  = (d_write != 2'd0) ? 3'd0 : d_read;
          m_off = m_a;
        end else if (m_gf) begin
          m_a       = if_addr;
          m_e.owner = 1'b0;
          m_e.addr  = 32'(m_a - (m_a % 4));
          m_e.we    = 1'b0;
          m_e.strb  = 4'h0;
          m_e.wdata = '0;
        end
        if (m_gd || m_gf) begin
          req_q.push_back(m_e);
          m_owner = m_gd;
          m_busy  = 1'b1;
        end
      end
      if (!if_req || m_gf) m_starve = 0;
      else if (m_gd && m_starve < SLIM) m_starve++;
    end
  end

  // Monitor: compares each new bus request and each ready pulse against the model
  req_t cur;
  rsp_t got;
  bit   prev_req = 1'b0;
  always @(negedge clk) begin
    if (!sb_en) begin
      prev_req = 1'b0;
    end else begin
      if (mem_req && !prev_req) begin
        if (req_q.size() == 0) begin
          fail_note("unexpected_grant", "bus request with nothing expected");
        end else begin
          cur = req_q.pop_front();
          owner_log.push_back(owner);
          check("grant_owner", 32'(owner), 32'(cur.owner));
          check("grant_addr", mem_addr, cur.addr);
          check("grant_we", 32'(mem_we), 32'(cur.we));
          check("grant_strb", 32'(mem_wstrb), 32'(cur.strb));
          if (cur.we) check("grant_wdata", mem_wdata, cur.wdata);
        end
      end else if (mem_req) begin
        check("bus_hold_addr", mem_addr, cur.addr);
        check("bus_hold_strb", 32'(mem_wstrb), 32'(cur.strb));
      end
      if (if_ready && d_ready) begin
        fail_note("dual_ready", "both ready pulses high");
      end else if (if_ready || d_ready) begin
        if (rsp_q.size() == 0) begin
          fail_note("unexpected_ready", "ready pulse with nothing expected");
        end else begin
          got = rsp_q.pop_front();
          check("ready_owner", 32'(d_ready), 32'(got.owner));
          if (got.chk) begin
            if (got.owner) check("d_rdata", d_rdata, got.data);
            else           check("if_rdata", if_rdata, got.data);
          end
        end
      end
      prev_req = mem_req;
    end
  end

  task automatic wait_ready(input bit is_d, input string name);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(is_d ? d_ready : if_ready) && t < BOUND);
    if (t >= BOUND) fail_note(name, "no ready pulse within bound");
  endtask

  task automatic wait_req(input string name);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!mem_req && t < BOUND);
    if (t >= BOUND) fail_note(name, "no mem_req within bound");
  endtask

  task automatic fetch_agent(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        if_req = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      if_req  = 1'b1;
      if_addr = 32'($urandom_range(0, 16383)) << 2;
      wait_ready(1'b0, "rand_fetch_wait");
    end
    if_req = 1'b0;
  endtask

  task automatic data_agent(input int n);
    int k;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        d_read  = 3'd0;
        d_write = 2'd0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      k       = $urandom_range(0, 9);
      d_addr  = 32'($urandom_range(0, 65535));
      d_wdata = $urandom;
      if (k < 5) begin
        d_read  = 3'($urandom_range(1, 5));
        d_write = 2'd0;
      end else if (k < 9) begin
        d_read  = 3'd0;
        d_write = 2'($urandom_range(1, 3));
      end else begin
        d_read  = 3'($urandom_range(1, 5));
        d_write = 2'($urandom_range(1, 3));
      end
      wait_ready(1'b1, "rand_data_wait");
    end
    d_read  = 3'd0;
    d_write = 2'd0;
  endtask

  bit exp_starve[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  int base_idx;
  int bus_cycles;
  bit quiet_ok;

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_if_ready", 32'(if_ready), 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_d_ready", 32'(d_ready), 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst   = 1'b0;
    sb_en = 1'b1;
    @(negedge clk);

    // Fetch only
    force_en  = 1'b1;
    force_val = 32'h0050_0093;
    min_lat   = 1'b1;
    if_req    = 1'b1;
    if_addr   = 32'h100;
    wait_req("fetch_only_req");
    check("fetch_only_addr", mem_addr, 32'h100);
    check("fetch_only_we", 32'(mem_we), 32'd0);
    wait_ready(1'b0, "fetch_only_wait");
    if_req = 1'b0;
    check("fetch_only_rdata", if_rdata, 32'h0050_0093);

    // Simultaneous fetch and LB: data first
    force_val = 32'h8011_2233;
    base_idx  = owner_log.size();
    if_addr   = 32'h300;
    if_req    = 1'b1;
    d_read    = 3'b001;
    d_addr    = 32'h203;
    wait_ready(1'b1, "lb_wait");
    d_read = 3'b000;
    check("lb_rdata", d_rdata, 32'hFFFF_FF80);
    wait_ready(1'b0, "fetch_after_lb");
    if_req = 1'b0;
    if (owner_log.size() >= base_idx + 2) begin
      check("simul_first_owner", 32'(owner_log[base_idx]), 32'd1);
      check("simul_second_owner", 32'(owner_log[base_idx + 1]), 32'd0);
    end else begin
      fail_note("simul_owner_log", "too few grants observed");
    end
    d_read = 3'b100;
    wait_ready(1'b1, "lbu_wait");
    d_read = 3'b000;
    check("lbu_rdata", d_rdata, 32'h0000_0080);

    // Stores
    d_write = 2'b10;
    d_addr  = 32'h202;
    d_wdata = 32'h1234_ABCD;
    wait_req("sh_req");
    check("sh_addr", mem_addr, 32'h200);
    check("sh_we", 32'(mem_we), 32'd1);
    check("sh_strb", 32'(mem_wstrb), 32'b1100);
    check("sh_wdata", mem_wdata, 32'hABCD_ABCD);
    wait_ready(1'b1, "sh_wait");
    d_write = 2'b01;
    d_addr  = 32'h201;
    wait_req("sb_req");
    check("sb_strb", 32'(mem_wstrb), 32'b0010);
    check("sb_wdata", mem_wdata, 32'hCDCD_CDCD);
    wait_ready(1'b1, "sb_wait");
    d_write = 2'b00;

    // Starvation: data kept busy while fetch waits
    force_en = 1'b0;
    base_idx = owner_log.size();
    if_addr  = 32'h400;
    if_req   = 1'b1;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          d_read = 3'b011;
          d_addr = 32'h500 + 32'(4 * i);
          wait_ready(1'b1, "starve_data");
        end
        d_read = 3'b000;
      end
      begin
        wait_ready(1'b0, "starve_fetch");
        if_req = 1'b0;
      end
    join
    if (owner_log.size() >= base_idx + 6) begin
      for (int i = 0; i < 6; i++)
        check($sformatf("starve_owner%0d", i), 32'(owner_log[base_idx + i]), 32'(exp_starve[i]));
    end else begin
      fail_note("starve_owner_log", "too few grants observed");
    end

    // Randomized mixed traffic
    min_lat = 1'b0;
    fork
      fetch_agent(60);
      data_agent(80);
    join
    repeat (10) @(negedge clk);
    check("drain_req_q", 32'(req_q.size()), 32'd0);
    check("drain_rsp_q", 32'(rsp_q.size()), 32'd0);
    sb_en = 1'b0;
    @(negedge clk);

`ifdef MEM_ARB_TIMEOUT_EN
    // Fetch that is never acknowledged
    hold_ack = 1'b1;
    if_req   = 1'b1;
    if_addr  = 32'h80;
    wait_req("tmo_req");
    bus_cycles = 0;
    while (mem_req && bus_cycles < BOUND) begin
      bus_cycles++;
      @(negedge clk);
    end
    check("tmo_bus_cycles", 32'(bus_cycles), 32'(TMO));
    check("tmo_if_ready", 32'(if_ready), 32'd1);
    check("tmo_if_rdata", if_rdata, 32'd0);
    check("tmo_err", 32'(err), 32'd1);
    if_req = 1'b0;
    repeat (3) @(negedge clk);
    check("tmo_err_sticky", 32'(err), 32'd1);
    hold_ack = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("tmo_err_cleared", 32'(err), 32'd0);
`else
    check("err_constant", 32'(err), 32'd0);
`endif

    // Reset in BUS with a simultaneous ack
    min_lat = 1'b1;
    if_req  = 1'b1;
    if_addr = 32'h40;
    wait_req("rst_mid_req");
    rst    = 1'b1;
    if_req = 1'b0;
    @(negedge clk);
    check("rst_mid_mem_req", 32'(mem_req), 32'd0);
    check("rst_mid_if_ready", 32'(if_ready), 32'd0);
    check("rst_mid_d_ready", 32'(d_ready), 32'd0);
    check("rst_mid_owner", 32'(owner), 32'd0);
    check("rst_mid_mem_addr", mem_addr, 32'd0);
    check("rst_mid_if_rdata", if_rdata, 32'd0);
    check("rst_mid_d_rdata", d_rdata, 32'd0);
    rst      = 1'b0;
    quiet_ok = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (if_ready || d_ready || mem_req) quiet_ok = 1'b0;
    end
    check("rst_mid_quiet", 32'(quiet_ok), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
